// File: rtl/fb_scanout_arbiter.sv
// fb_scanout_arbiter
// Shares one single-port framebuffer RAM between VGA scan-out and a pixel
// writer. A read slot is reserved on every SCALE-th pixel clock inside the
// upscaled framebuffer area. Every other cycle is offered to the writer.
//
// Write handshake: a write transfers on a cycle where wr_valid_in and
// wr_ready_out are both high. wr_ready_out depends only on the timing inputs,
// never on wr_valid_in. While waiting, the requester holds wr_valid_in,
// wr_addr_in and wr_data_in stable.
module fb_scanout_arbiter #(
    parameter int FB_WIDTH    = 256,
    parameter int FB_HEIGHT   = 192,
    parameter int SCALE       = 4,
    parameter int PIXEL_WIDTH = 16,
    parameter int ADDR_WIDTH  = 16,
    parameter int MEM_LATENCY = 2
) (
    input  logic                   pixel_clk_in,
    input  logic                   rst_n_in,
    input  logic [10:0]            hcount_in,
    input  logic [9:0]             vcount_in,
    input  logic                   blank_in,
    input  logic [ADDR_WIDTH-1:0]  wr_addr_in,
    input  logic [PIXEL_WIDTH-1:0] wr_data_in,
    input  logic                   wr_valid_in,
    output logic                   wr_ready_out,
    output logic [ADDR_WIDTH-1:0]  mem_addr_out,
    output logic [PIXEL_WIDTH-1:0] mem_wdata_out,
    output logic                   mem_en_out,
    output logic                   mem_we_out,
    input  logic [PIXEL_WIDTH-1:0] mem_rdata_in,
    output logic [PIXEL_WIDTH-1:0] pixel_out,
    output logic                   pixel_valid_out,
    output logic [15:0]            drop_count_out
);

    // SCALE is a power of two, so scaling reduces to shifts and masks.
    localparam int                    SCALE_SHIFT = $clog2(SCALE);
    localparam logic [11:0]           H_LIMIT     = 12'(FB_WIDTH * SCALE);
    localparam logic [10:0]           V_LIMIT     = 11'(FB_HEIGHT * SCALE);
    localparam logic [10:0]           PHASE_MASK  = 11'(SCALE - 1);
    localparam logic [ADDR_WIDTH:0]   FB_PIXELS   = (ADDR_WIDTH + 1)'(FB_WIDTH * FB_HEIGHT);
    localparam logic [ADDR_WIDTH-1:0] FB_W_A      = ADDR_WIDTH'(FB_WIDTH);

    // Timing decode.
    logic                  active;
    logic                  rd_slot;
    logic [10:0]           fb_x;
    logic [9:0]            fb_y;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  wr_in_range;

    // Registered state.
    logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [PIXEL_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                   mem_en_q, mem_en_d;
    logic                   mem_we_q, mem_we_d;
    logic [15:0]            drop_q, drop_d;
    logic [MEM_LATENCY:0]   tag_q, tag_d;
    logic [MEM_LATENCY:0]   act_q, act_d;
    logic [PIXEL_WIDTH-1:0] hold_q, hold_d;
    logic [PIXEL_WIDTH-1:0] pixel_q, pixel_d;
    logic                   valid_q, valid_d;

    // The phase of the read slot is taken straight from hcount_in, so a
    // line wrap or a jump in the timing inputs realigns it immediately.
    assign active      = !blank_in
                         && ({1'b0, hcount_in} < H_LIMIT)
                         && ({1'b0, vcount_in} < V_LIMIT);
    assign rd_slot     = active && ((hcount_in & PHASE_MASK) == 11'd0);
    assign fb_x        = hcount_in >> SCALE_SHIFT;
    assign fb_y        = vcount_in >> SCALE_SHIFT;
    assign rd_addr     = ADDR_WIDTH'(fb_y) * FB_W_A + ADDR_WIDTH'(fb_x);
    assign wr_in_range = ({1'b0, wr_addr_in} < FB_PIXELS);

    // The reader owns the port during a read slot. This single rule is what
    // keeps a read and a write from ever being issued in the same cycle.
    assign wr_ready_out = !rd_slot;

    // Choose the memory command for the next cycle and update the drop counter.
    always_comb begin
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        drop_d      = drop_q;
        if (rd_slot) begin
            mem_en_d   = 1'b1;
            mem_addr_d = rd_addr;
        end else if (wr_valid_in) begin
            if (wr_in_range) begin
                mem_en_d    = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = wr_addr_in;
                mem_wdata_d = wr_data_in;
            end else if (drop_q != 16'hFFFF) begin
                drop_d = drop_q + 16'd1;
            end
        end
    end

    // Shift the read tags and active flags. Stage MEM_LATENCY of the tag chain
    // lines up with the returning RAM data.
    always_comb begin
        tag_d    = '0;
        act_d    = '0;
        tag_d[0] = rd_slot;
        act_d[0] = active;
        for (int i = 1; i <= MEM_LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
            act_d[i] = act_q[i-1];
        end
    end

    // Latch read data when its tag emerges. The output pixel is forced to zero
    // whenever the delayed active flag shows border or blank.
    always_comb begin
        hold_d  = tag_q[MEM_LATENCY] ? mem_rdata_in : hold_q;
        valid_d = act_q[MEM_LATENCY];
        pixel_d = act_q[MEM_LATENCY] ? hold_d : '0;
    end

    // All state registers. An asynchronous reset also discards in-flight reads.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            drop_q      <= '0;
            tag_q       <= '0;
            act_q       <= '0;
            hold_q      <= '0;
            pixel_q     <= '0;
            valid_q     <= 1'b0;
        end else begin
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            drop_q      <= drop_d;
            tag_q       <= tag_d;
            act_q       <= act_d;
            hold_q      <= hold_d;
            pixel_q     <= pixel_d;
            valid_q     <= valid_d;
        end
    end

    assign mem_addr_out    = mem_addr_q;
    assign mem_wdata_out   = mem_wdata_q;
    assign mem_en_out      = mem_en_q;
    assign mem_we_out      = mem_we_q;
    assign drop_count_out  = drop_q;
    assign pixel_out       = pixel_q;
    assign pixel_valid_out = valid_q;

endmodule

// File: tb/tb_fb_scanout_arbiter.sv
// Bench for fb_scanout_arbiter. It provides a RAM model with a two-cycle
// read latency and a reference model built from the display geometry.
module tb_fb_scanout_arbiter;

    localparam int FB_W   = 256;
    localparam int FB_H   = 192;
    localparam int SC     = 4;
    localparam int FB_PIX = FB_W * FB_H;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic        blank = 1'b1;
    logic [15:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready_out;
    logic [15:0] mem_addr_out, mem_wdata_out, mem_rdata_in;
    logic        mem_en_out, mem_we_out;
    logic [15:0] pixel_out;
    logic        pixel_valid_out;
    logic [15:0] drop_count_out;

    fb_scanout_arbiter dut (
        .pixel_clk_in    (clk),
        .rst_n_in        (rst_n),
        .hcount_in       (hcount),
        .vcount_in       (vcount),
        .blank_in        (blank),
        .wr_addr_in      (wr_addr),
        .wr_data_in      (wr_data),
        .wr_valid_in     (wr_valid),
        .wr_ready_out    (wr_ready_out),
        .mem_addr_out    (mem_addr_out),
        .mem_wdata_out   (mem_wdata_out),
        .mem_en_out      (mem_en_out),
        .mem_we_out      (mem_we_out),
        .mem_rdata_in    (mem_rdata_in),
        .pixel_out       (pixel_out),
        .pixel_valid_out (pixel_valid_out),
        .drop_count_out  (drop_count_out)
    );

    // ---------------- RAM model ----------------
    function automatic logic [15:0] init_word(input int a);
        if (a == 0) return 16'h1234;
        return 16'(a * 40503) ^ 16'h5A5A;
    endfunction

    logic [15:0] ram [65536];
    logic        ram_wr [65536];
    logic [15:0] rd_pipe1 = '0, rd_pipe2 = '0;

    function automatic logic [15:0] ram_word(input int a);
        return ram_wr[a] ? ram[a] : init_word(a);
    endfunction

    always @(posedge clk) begin
        if (mem_en_out && mem_we_out) begin
            ram[mem_addr_out]    <= mem_wdata_out;
            ram_wr[mem_addr_out] <= 1'b1;
        end
        if (mem_en_out && !mem_we_out) rd_pipe1 <= ram_word(int'(mem_addr_out));
        rd_pipe2 <= rd_pipe1;
    end
    assign mem_rdata_in = rd_pipe2;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a framebuffer image, the expected memory command and
    // one expected {valid,pixel} entry per cycle, queued for four cycles.
    logic [15:0] ref_mem [65536];
    logic [16:0] exp_q[$];
    logic        exp_en, exp_we, exp_ready, last_acc;
    logic [15:0] exp_addr, exp_wdata, exp_drop, latest;

    function automatic logic model_active(input int h, input int v, input logic b);
        return !b && (h < FB_W * SC) && (v < FB_H * SC);
    endfunction

    task automatic model_init();
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(17'd0);
        exp_en = 0; exp_we = 0; exp_addr = 0; exp_wdata = 0;
        exp_drop = 0; latest = 0; last_acc = 0;
    endtask

    // Checks the outputs for the current cycle, then advances the model by one cycle.
    task automatic check_and_step();
        logic        act, slot;
        logic [16:0] e;
        int          h, v, ra;
        h    = int'(hcount);
        v    = int'(vcount);
        act  = model_active(h, v, blank);
        slot = act && (h % SC == 0);
        exp_ready = !slot;
        check("wr_ready", wr_ready_out, exp_ready);
        check("mem_en", mem_en_out, exp_en);
        check("mem_we", mem_we_out, exp_we);
        check("mem_addr", mem_addr_out, exp_addr);
        if (!(exp_en && !exp_we)) check("mem_wdata", mem_wdata_out, exp_wdata);
        e = exp_q.pop_front();
        check("pix_valid", pixel_valid_out, e[16]);
        check("pixel", pixel_out, e[15:0]);
        check("drop_count", drop_count_out, exp_drop);
        last_acc = wr_valid && exp_ready;
        exp_en = 0;
        exp_we = 0;
        if (slot) begin
            ra       = (v / SC) * FB_W + h / SC;
            exp_en   = 1;
            exp_addr = 16'(ra);
            latest   = ref_mem[ra];
        end else if (wr_valid) begin
            if (int'(wr_addr) < FB_PIX) begin
                exp_en    = 1;
                exp_we    = 1;
                exp_addr  = wr_addr;
                exp_wdata = wr_data;
                ref_mem[int'(wr_addr)] = wr_data;
            end else if (exp_drop != 16'hFFFF) begin
                exp_drop = exp_drop + 1;
            end
        end
        exp_q.push_back({act, act ? latest : 16'h0});
    endtask

    // ---------------- driver ----------------
    // Drives one cycle of inputs. On return we are 1 time unit after the
    // next rising edge, so the registered outputs show the following cycle.
    task automatic drive_cycle(input int h, input int v, input logic b,
                               input logic wv, input logic [15:0] wa, input logic [15:0] wd);
        hcount   = 11'(h);
        vcount   = 10'(v);
        blank    = b;
        wr_valid = wv;
        wr_addr  = wa;
        wr_data  = wd;
        @(negedge clk);
        check_and_step();
        @(posedge clk);
        #1;
    endtask

    int          nwe, nrd, nacc, h, v, wide;
    logic        pend, b;
    logic [15:0] pa, pd;
    logic [15:0] act_data [16];

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ref_mem[i] = init_word(i);
            ram_wr[i]  = 1'b0;
        end
        hcount = 11'd1100;
        blank  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        // Reset values.
        check("rst_en", mem_en_out, 0);
        check("rst_we", mem_we_out, 0);
        check("rst_addr", mem_addr_out, 0);
        check("rst_pixel", pixel_out, 0);
        check("rst_valid", pixel_valid_out, 0);
        check("rst_drop", drop_count_out, 0);
        check("rst_ready", wr_ready_out, 1);
        rst_n = 1'b1;
        model_init();

        // Single read of address 0.
        for (int i = 0; i < 8; i++) begin
            drive_cycle(i, 0, 0, 0, 0, 0);
            if (i == 0) begin
                check("sr_addr", mem_addr_out, 0);
                check("sr_en", mem_en_out, 1);
                check("sr_we", mem_we_out, 0);
            end
            if (i >= 3 && i <= 6) begin
                check("sr_pixel", pixel_out, 16'h1234);
                check("sr_valid", pixel_valid_out, 1);
            end
        end

        // Address mapping at the last framebuffer pixel, then into blanking.
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1020 + i, 767, (i >= 4), 0, 0, 0);
            if (i == 0) check("map_addr", mem_addr_out, 49151);
            if (i == 3) begin
                check("map_valid", pixel_valid_out, 1);
                check("map_pixel", pixel_out, init_word(49151));
            end
            if (i == 7) check("map_blank_valid", pixel_valid_out, 0);
        end

        // Writes with valid held high during active area.
        nwe = 0; nrd = 0; nacc = 0;
        for (int i = 0; i < 16; i++) act_data[i] = 16'($urandom);
        for (int i = 0; i < 16; i++) begin
            drive_cycle(i, 0, 0, 1, 16'(100 + nacc), act_data[nacc]);
            check("act_ready", wr_ready_out, (i % SC) != 0);
            if (mem_en_out && mem_we_out) nwe++;
            if (mem_en_out && !mem_we_out) nrd++;
            if (last_acc) nacc++;
        end
        drive_cycle(1100, 0, 1, 0, 0, 0);
        drive_cycle(1101, 0, 1, 0, 0, 0);
        check("act_writes", nwe, 12);
        check("act_reads", nrd, 4);
        for (int i = 0; i < 12; i++) check("act_ram", ram_word(100 + i), act_data[i]);

        // Full write bandwidth during blanking.
        nwe = 0;
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1100 + i, 0, 1, 1, 16'(200 + i), 16'(i));
            if (mem_we_out && mem_en_out) nwe++;
        end
        check("blank_writes", nwe, 10);

        // Out-of-range write is accepted and dropped.
        check("oor_drop_before", drop_count_out, 0);
        drive_cycle(1200, 0, 1, 1, 16'd49152, 16'hBEEF);
        check("oor_en", mem_en_out, 0);
        check("oor_drop_after", drop_count_out, 1);
        drive_cycle(1201, 0, 1, 0, 0, 0);

        // Randomized scanning with a well-behaved writer.
        pend = 0; pa = 0; pd = 0;
        for (int seg = 0; seg < 16; seg++) begin
            h    = $urandom_range(0, 1343);
            v    = (seg % 2 == 1) ? $urandom_range(0, 11) : $urandom_range(0, 805);
            wide = $urandom_range(0, 1);
            for (int c = 0; c < 200; c++) begin
                b = (wide == 1) ? (h >= 1280 || v >= 800) : (h >= 1024 || v >= 768);
                if ($urandom_range(0, 15) == 0) b = 1;
                if (!pend && $urandom_range(0, 2) != 0) begin
                    pend = 1;
                    pa = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(49152, 65535))
                                                     : 16'($urandom_range(0, 511));
                    pd = 16'($urandom);
                end
                drive_cycle(h, v, b, pend, pa, pd);
                if (last_acc) pend = 0;
                h++;
                if (h == 1344) begin
                    h = 0;
                    v++;
                    if (v == 806) v = 0;
                end
            end
        end

        // Asynchronous reset in the middle of active scan-out.
        for (int i = 0; i < 12; i++) drive_cycle(40 + i, 20, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_en", mem_en_out, 0);
        check("mid_rst_we", mem_we_out, 0);
        check("mid_rst_addr", mem_addr_out, 0);
        check("mid_rst_wdata", mem_wdata_out, 0);
        check("mid_rst_pixel", pixel_out, 0);
        check("mid_rst_valid", pixel_valid_out, 0);
        check("mid_rst_drop", drop_count_out, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_init();
        for (int i = 0; i < 8; i++) begin
            drive_cycle(56 + i, 20, 0, 0, 0, 0);
            if (i < 3) check("post_rst_novalid", pixel_valid_out, 0);
            if (i == 3) check("post_rst_valid", pixel_valid_out, 1);
        end

        // Drop counter saturation.
        for (int i = 0; i < 65535; i++) drive_cycle(1100, 800, 1, 1, 16'hFFFF, 16'h0);
        check("drop_sat", drop_count_out, 16'hFFFF);
        drive_cycle(1100, 800, 1, 1, 16'hC000, 16'h0);
        check("drop_sat_hold", drop_count_out, 16'hFFFF);
        drive_cycle(1100, 800, 1, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_scanout_arbiter.md
# fb_scanout_arbiter

Shares one single-port framebuffer RAM between the VGA scan-out reader and a pixel-write requester such as the Ethernet video receiver. It sits between the VGA timing generator (hcount/vcount/blank) and the framebuffer BRAM. It schedules a guaranteed read slot once every SCALE pixel clocks during active framebuffer area, upscaling a FB_WIDTH×FB_HEIGHT buffer onto the display. All other memory cycles go to the writer through a valid/ready handshake.

## Interface
- FB_WIDTH, 256, framebuffer pixels per line
- FB_HEIGHT, 192, framebuffer lines
- SCALE, 4, display pixels per framebuffer pixel in each axis; power of 2
- PIXEL_WIDTH, 16, bits per pixel
- ADDR_WIDTH, 16, RAM address width; must be ≥ clog2(FB_WIDTH*FB_HEIGHT)
- MEM_LATENCY, 2, RAM read latency in cycles (address registered → data valid)

Ports:
- pixel_clk_in  in  1  pixel clock; the only clock
- rst_n_in  in  1  asynchronous, active-low reset
- hcount_in  in  11  pixel number from the timing generator
- vcount_in  in  10  line number from the timing generator
- blank_in  in  1  blanking from the timing generator
- wr_addr_in  in  ADDR_WIDTH  write address (linear, y*FB_WIDTH+x)
- wr_data_in  in  PIXEL_WIDTH  write pixel
- wr_valid_in  in  1  write request
- wr_ready_out  out  1  write accepted this cycle when high together with wr_valid_in
- mem_addr_out  out  ADDR_WIDTH  RAM address, registered
- mem_wdata_out  out  PIXEL_WIDTH  RAM write data, registered
- mem_en_out  out  1  RAM enable, registered
- mem_we_out  out  1  RAM write enable, registered
- mem_rdata_in  in  PIXEL_WIDTH  RAM read data
- pixel_out  out  PIXEL_WIDTH  scan-out pixel, registered
- pixel_valid_out  out  1  pixel_out is framebuffer data; 0 means border or blank
- drop_count_out  out  16  count of dropped out-of-range writes, saturating

## Operation
- **Active region:** `active = !blank_in && hcount_in < FB_WIDTH*SCALE && vcount_in < FB_HEIGHT*SCALE`.
- **Read slot:** `rd_slot = active && hcount_in[log2(SCALE)-1:0] == 0`.
- **Read address:** `(vcount_in >> log2 SCALE) * FB_WIDTH + (hcount_in >> log2 SCALE)`, computed in ADDR_WIDTH bits. Use shifts only.
- **Write ready:** `wr_ready_out = !rd_slot`, combinational from hcount_in, vcount_in and blank_in. It does not depend on wr_valid_in.
- **Next-cycle memory command:**
  - rd_slot: mem_en=1, mem_we=0, addr = read address.
  - Otherwise, write accepted with wr_addr_in < FB_WIDTH*FB_HEIGHT: mem_en=1, mem_we=1, addr/wdata from the request.
  - Otherwise, write accepted but out of range: mem_en=0, and drop_count increments unless it is already 0xFFFF.
  - Otherwise: mem_en=0, mem_we=0. mem_addr_out and mem_wdata_out hold their values.
- **Read and write never collide:** a write request presented during a read slot waits, because ready is low. The requester must hold wr_valid_in and its data stable until accepted.
- **Read tracking:**
  - A read-tag shift register of depth MEM_LATENCY+1 tracks in-flight reads.
  - When a tag emerges, pixel_out ← mem_rdata_in.
  - pixel_out then holds that value until the next emerging tag.
- **pixel_valid_out:** `active` delayed by MEM_LATENCY+2 cycles through a separate shift register. When that delayed bit is 0, pixel_out is forced to 0.
- **Blanking and border:** during blank and border every cycle is write-eligible, so the writer gets 100% bandwidth.

## Timing
- **Reset values:** all outputs and shift registers are 0 on reset: wr_ready_out follows its combinational equation; mem_* = 0; pixel_out = 0; pixel_valid_out = 0; drop_count_out = 0.
- **Reset mid-operation:** in-flight reads are discarded. The first valid pixel after release needs a new read slot.
- **Read pipeline (cycle T = rd_slot with hcount_in = h):**
  - T+1: mem_addr_out valid, mem_en=1, mem_we=0.
  - T+1+MEM_LATENCY: mem_rdata_in valid.
  - T+2+MEM_LATENCY: pixel_out valid; it stays constant for SCALE cycles.
- **Scan-out latency:** pixel_out and pixel_valid_out lag hcount_in by exactly MEM_LATENCY+2 cycles (4 at defaults). Top level delays hsync, vsync and blank by the same amount.
- **Write latency:** an accepted write appears on the memory port at the next cycle. Throughput is (SCALE-1)/SCALE during active area and 1 per cycle otherwise.
- **Line wrap:** hcount_in wraps to 0 at line end. The slot phase realigns from hcount_in, not from an internal counter.

## Test plan
- **Reset:** assert rst_n_in low mid-frame → all outputs 0 immediately (asynchronous), drop_count_out=0. After release, no pixel_valid_out until 4 cycles after the next read slot.
- **Single read:** RAM model has addr 0 = 0x1234; drive hcount 0→3, vcount 0 → mem_addr_out=0 with en=1, we=0 at cycle 1. pixel_out=0x1234 with valid=1 at cycles 4–7.
- **Address mapping:** hcount=1020, vcount=767 → mem_addr_out=49151. hcount=1024 (blank) → no read, pixel_valid_out=0 four cycles later.
- **Active-area writes:** hold wr_valid_in high with incrementing addresses while hcount runs 0..15 → wr_ready_out low at hcount 0, 4, 8, 12. Exactly 12 writes land in RAM, and no cycle has read and write together.
- **Blanking bandwidth:** assert blank_in for 10 cycles with continuous valid → 10 consecutive writes with mem_we_out=1.
- **Out-of-range write:** write address 49152 → accepted, mem_en_out=0, drop_count_out 0→1. Preload the count at 0xFFFF → it stays 0xFFFF.
